// File: rtl/picorv_awb_pkg.sv
// Shared types and helpers for the picorv async-writeback arbiter.
// Optional build macro: PICORV_AWB_ARB_FIXED_PRIO_EN (fixed priority).
package picorv_awb_pkg;

  typedef logic [4:0] regaddr_t;

  localparam int NREGS = 32;

  function automatic int idx_wrap(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/picorv_rr_pick.sv
// Combinational rotating-priority picker: first set request at or
// after the start pointer, wrapping modulo N.
module picorv_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);

  localparam int PW = $clog2(N);

  logic          found;
  logic [PW:0]   s;
  logic [PW-1:0] p;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    s     = '0;
    p     = '0;
    for (int k = 0; k < N; k++) begin
      s = {1'b0, start} + (PW+1)'(k);
      if (s >= (PW+1)'(N))
        s = s - (PW+1)'(N);
      p = s[PW-1:0];
      if (!found && req[p]) begin
        found  = 1'b1;
        gnt[p] = 1'b1;
        idx    = p;
      end
    end
  end

endmodule

// File: rtl/picorv_awb_arb.sv
// Arbitrates NREQ late-writeback requesters onto the core awb port and
// tracks pending rd. Macro PICORV_AWB_ARB_FIXED_PRIO_EN: fixed priority.
module picorv_awb_arb
  import picorv_awb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREQ = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*5-1:0]  req_addr,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic               awb_valid,
  input  logic               awb_ready,
  output logic [4:0]         awb_addr,
  output logic [XLEN-1:0]    awb_data,
  input  logic               issue_valid,
  input  logic [4:0]         issue_addr,
  output logic [NREGS-1:0]   pending,
  output logic               awb_err
);

  localparam int PW = $clog2(NREQ);

  logic            load;
  logic            acc;
  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gidx;
  logic [PW-1:0]   start;
  regaddr_t        sel_addr;
  logic [XLEN-1:0] sel_data;
  logic [NREGS-1:0] set_v;
  logic [NREGS-1:0] clr_v;
  logic [NREGS-1:0] pend_nxt;
  logic            err_evt;

  assign load      = !awb_valid || awb_ready;
  assign req_ready = load ? gnt : '0;
  assign acc       = |(req_valid & req_ready);
  assign sel_addr  = req_addr[5*gidx +: 5];
  assign sel_data  = req_data[XLEN*gidx +: XLEN];

  picorv_rr_pick #(.N(NREQ)) u_pick (
    .req   (req_valid),
    .start (start),
    .gnt   (gnt),
    .idx   (gidx)
  );

`ifdef PICORV_AWB_ARB_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [PW-1:0] rr_ptr;

  assign start = rr_ptr;

  always_ff @(posedge clock) begin
    if (reset)
      rr_ptr <= '0;
    else if (acc)
      rr_ptr <= PW'(idx_wrap(int'(gidx), NREQ));
  end
`endif

  // Set is applied after clear so a same-cycle reissue keeps the bit.
  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (issue_valid && issue_addr != 5'd0)
      set_v = NREGS'(1) << issue_addr;
    if (awb_valid && awb_ready)
      clr_v = NREGS'(1) << awb_addr;
    pend_nxt = ((pending & ~clr_v) | set_v) & ~NREGS'(1);
  end

  assign err_evt = (acc && (sel_addr == 5'd0 || !pending[sel_addr]))
                || (issue_valid && issue_addr != 5'd0
                    && pending[issue_addr]);

  always_ff @(posedge clock) begin
    if (reset) begin
      awb_valid <= 1'b0;
      awb_addr  <= '0;
      awb_data  <= '0;
      pending   <= '0;
      awb_err   <= 1'b0;
    end else begin
      pending <= pend_nxt;
      if (acc) begin
        awb_valid <= 1'b1;
        awb_addr  <= sel_addr;
        awb_data  <= sel_data;
      end else if (awb_ready) begin
        awb_valid <= 1'b0;
      end
      if (err_evt)
        awb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_picorv_awb_arb.sv
// Directed bench for picorv_awb_arb with a per-cycle reference model.
// Honors PICORV_AWB_ARB_FIXED_PRIO_EN for the expected grant order.
module tb_picorv_awb_arb;

  localparam int XLEN = 32;
  localparam int NREQ = 4;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*5-1:0]    req_addr = '0;
  logic [NREQ*XLEN-1:0] req_data = '0;
  logic                 awb_valid;
  logic                 awb_ready = 1'b0;
  logic [4:0]           awb_addr;
  logic [XLEN-1:0]      awb_data;
  logic                 issue_valid = 1'b0;
  logic [4:0]           issue_addr = '0;
  logic [31:0]          pending;
  logic                 awb_err;

  int tests = 0;
  int fails = 0;
  int glog[$];

  always #5 clock = ~clock;

  picorv_awb_arb #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .awb_valid   (awb_valid),
    .awb_ready   (awb_ready),
    .awb_addr    (awb_addr),
    .awb_data    (awb_data),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .pending     (pending),
    .awb_err     (awb_err)
  );

  // Reference model: one output slot, a rotating pointer, a pending set.
  bit          m_valid = 0;
  bit [4:0]    m_addr  = 0;
  bit [31:0]   m_data  = 0;
  int          m_ptr   = 0;
  bit [31:0]   m_pend  = 0;
  bit          m_err   = 0;

  function automatic int exp_gnt();
    int i;
    if (m_valid && !awb_ready) return -1;
    for (int k = 0; k < NREQ; k++) begin
      i = (m_ptr + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin : mdl
    int g;
    bit [31:0] old;
    bit hs;
    bit [4:0] a;
    @(posedge clock);
    if (reset) begin
      m_valid = 0; m_addr = 0; m_data = 0;
      m_ptr = 0; m_pend = 0; m_err = 0;
    end else begin
      g   = exp_gnt();
      old = m_pend;
      hs  = m_valid && awb_ready;
      if (hs) m_pend[m_addr] = 1'b0;
      if (issue_valid && issue_addr != 0) begin
        if (old[issue_addr]) m_err = 1;
        m_pend[issue_addr] = 1'b1;
      end
      if (g >= 0) begin
        a = req_addr[5*g +: 5];
        if (a == 0 || !old[a]) m_err = 1;
        m_valid = 1;
        m_addr  = a;
        m_data  = req_data[XLEN*g +: XLEN];
`ifndef PICORV_AWB_ARB_FIXED_PRIO_EN
        m_ptr = (g + 1) % NREQ;
`endif
      end else if (hs) begin
        m_valid = 0;
      end
    end
  end

  initial forever begin : cmp
    int g;
    logic [NREQ-1:0] er;
    @(negedge clock);
    g  = exp_gnt();
    er = (g >= 0) ? NREQ'(1) << g : '0;
    chk("m_ready", req_ready, er);
    chk("m_valid", awb_valid, m_valid);
    chk("m_pend", pending, m_pend);
    chk("m_err", awb_err, m_err);
    if (m_valid) begin
      chk("m_addr", awb_addr, m_addr);
      chk("m_data", awb_data, m_data);
    end
  end

  task automatic cyc();
    logic [NREQ-1:0] acc;
    @(negedge clock);
    acc = req_valid & req_ready;
    for (int i = 0; i < NREQ; i++)
      if (acc[i]) glog.push_back(i);
    @(posedge clock);
    #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic pres(input int i, input logic [4:0] a,
                      input logic [31:0] d);
    req_valid[i] = 1'b1;
    req_addr[5*i +: 5] = a;
    req_data[XLEN*i +: XLEN] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    issue_valid = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic issue(input logic [4:0] a);
    issue_valid = 1'b1;
    issue_addr = a;
    cyc();
    issue_valid = 1'b0;
  endtask

  int exp_g[5];
  logic [31:0] snap;

  initial begin
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk("rst_valid", awb_valid, 0);
    chk("rst_pend", pending, 0);
    chk("rst_err", awb_err, 0);
    chk("rst_ready", req_ready, 0);

    // single writeback
    issue(5);
    chk("t1_pend_set", pending, 32'h20);
    pres(2, 5, 32'hDEADBEEF);
    awb_ready = 1'b1;
    #1;
    chk("t1_ready", req_ready, 4'b0100);
    cyc();
    chk("t1_valid", awb_valid, 1);
    chk("t1_addr", awb_addr, 5);
    chk("t1_data", awb_data, 32'hDEADBEEF);
    chk("t1_pend_hold", pending, 32'h20);
    cyc();
    chk("t1_pend_clr", pending, 0);
    chk("t1_err", awb_err, 0);

    // continuous contention
    do_reset();
    for (int r = 1; r <= 5; r++) issue(5'(r));
    glog.delete();
    for (int i = 0; i < NREQ; i++) pres(i, 5'(i + 1), 32'h100 + i);
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk("t2_valid", awb_valid, 1);
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i]) pres(i, 5'(i + 1), 32'h200 + 32'(c * 8 + i));
    end
    req_valid = '0;
    cyc();
    cyc();
`ifdef PICORV_AWB_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0, 0};
`else
    exp_g = '{0, 1, 2, 3, 0};
`endif
    chk("t2_gcount", glog.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < glog.size()) chk("t2_grant", glog[k], exp_g[k]);

    // backpressure
    do_reset();
    issue(10);
    issue(11);
    issue(12);
    awb_ready = 1'b0;
    pres(0, 10, 32'hA0A0);
    cyc();
    pres(1, 11, 32'hB1B1);
    pres(2, 12, 32'hC2C2);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t3_ready0", req_ready, 0);
      chk("t3_addr", awb_addr, 10);
      chk("t3_data", awb_data, 32'hA0A0);
      cyc();
    end
    awb_ready = 1'b1;
    #1;
    chk("t3_ready1", req_ready, 4'b0010);
    cyc();
    chk("t3_next", awb_addr, 11);
    cyc();
    chk("t3_next2", awb_addr, 12);
    cyc();
    chk("t3_drain", awb_valid, 0);

    // reissue during completion, and x0 issue
    issue(7);
    pres(3, 7, 32'h7777);
    cyc();
    issue_valid = 1'b1;
    issue_addr = 7;
    cyc();
    issue_valid = 1'b0;
    chk("t4_pend7", pending[7], 1);
    chk("t4_err", awb_err, 1);
    snap = pending;
    issue(0);
    chk("t4_x0", pending, snap);

    // unexpected writeback
    do_reset();
    pres(1, 9, 32'h9999);
    cyc();
    chk("t5_valid", awb_valid, 1);
    chk("t5_addr", awb_addr, 9);
    chk("t5_err", awb_err, 1);
    cyc();
    cyc();
    cyc();
    chk("t5_sticky", awb_err, 1);

    // reset with a stalled entry
    do_reset();
    issue(3);
    awb_ready = 1'b0;
    pres(2, 3, 32'h3333);
    cyc();
    pres(0, 3, 32'h4444);
    reset = 1'b1;
    #1;
    chk("t6_ready_rst", req_ready, 0);
    cyc();
    reset = 1'b0;
    chk("t6_valid", awb_valid, 0);
    chk("t6_pend", pending, 0);
    chk("t6_err", awb_err, 0);
    pres(2, 3, 32'h3333);
    #1;
    chk("t6_restart", req_ready, 4'b0001);
    cyc();
    req_valid = '0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/picorv_awb_arb.md
Name: picorv_awb_arb

Overview:
- Shares the core's single async-writeback (awb) port between NREQ coprocessor/PCPI requesters that complete register writes late.
- Round-robin arbitration into a one-entry registered output stage.
- Keeps a 32-bit pending-register mask: set on async issue, cleared on awb completion. The mask is exported for hazard checks.
- Sits between the coprocessors and picorv_ctrl's awb_valid/awb_ready/awb_addr/awb_data inputs.

Parameters:
- XLEN, 32, register data width.
- NREQ, 4, number of requesters (2..8).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester writeback request.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_addr  in  NREQ*5  packed destination register addresses; requester i at [5*i+:5].
- req_data  in  NREQ*XLEN  packed writeback data; requester i at [XLEN*i+:XLEN].
- awb_valid  out  1  to core async writeback.
- awb_ready  in  1  from core.
- awb_addr  out  5  register address of current writeback.
- awb_data  out  XLEN  writeback data.
- issue_valid  in  1  async-writeback instruction retired by core (pcpi_ready && pcpi_wb_async).
- issue_addr  in  5  rd of that instruction.
- pending  out  32  pending-register mask; bit 0 always 0.
- awb_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset values:
  - awb_valid=0; awb_addr=0; awb_data=0; pending=0; awb_err=0.
  - rr_ptr=0; req_ready=0 combinationally, since the stage is empty.
- Output stage load condition: load = !awb_valid || awb_ready. The stage can refill in the same cycle it drains, so throughput is 1 writeback/cycle.
- Arbitration (combinational):
  - When load && |req_valid, grant g = first i with req_valid[i], scanning from rr_ptr upward modulo NREQ.
  - req_ready[g]=1; all other bits 0.
  - When !load, req_ready=0.
- Acceptance (on the posedge where req_valid[g] && req_ready[g]):
  - awb_valid<=1, awb_addr<=req_addr[g], awb_data<=req_data[g].
  - rr_ptr<=(g+1) mod NREQ.
- Drain: on awb_valid && awb_ready with no acceptance that cycle, awb_valid<=0.
- Output stability: awb_addr/awb_data are held stable while awb_valid && !awb_ready.
- Latency: request to awb_valid is 1 cycle; a requester is never accepted twice for one request.
- Requester rule: a requester holds valid/addr/data stable until its req_ready. Dropping valid without ready is permitted and has no effect.
- Pending mask:
  - issue_valid && issue_addr!=0 sets pending[issue_addr].
  - awb handshake (awb_valid && awb_ready) clears pending[awb_addr].
  - Set and clear on the same address in the same cycle: set wins.
  - issue_addr=0 is ignored.
- awb_err: set and held until reset when any of the following occurs:
  - acceptance of req_addr with pending bit 0;
  - acceptance of req_addr=0;
  - issue_valid to an address already pending.
  
  The offending writeback is still forwarded.
- Reset mid-operation: any in-flight output entry is discarded (awb_valid=0 on next cycle), and mask, pointer and error are cleared. Requesters must re-present after reset.
- rr_ptr width: $clog2(NREQ). Wrap is explicit modulo NREQ, so non-power-of-two NREQ is legal.

Optional Feature:
- PICORV_AWB_ARB_FIXED_PRIO_EN:
  - When defined: fixed priority, lowest index wins; rr_ptr is removed.
  - When undefined: round-robin as above.
- Pending mask and awb_err behave identically in both builds.

Decomposition:
- Package picorv_awb_pkg:
  - typedef regaddr_t (logic [4:0]);
  - constant NREGS=32;
  - function idx_wrap for modulo-NREQ increment.
- Sub-module picorv_rr_pick:
  - combinational; inputs req vector and start pointer; outputs one-hot grant and grant index;
  - used for round-robin;
  - under PICORV_AWB_ARB_FIXED_PRIO_EN, start pointer is tied to 0.

Test Plan:
- Issue x5, then requester 2 presents addr 5, data 0xDEADBEEF, awb_ready=1 → req_ready[2] in cycle 0; awb_valid, addr 5, data 0xDEADBEEF in cycle 1; pending[5] clears in cycle 2; awb_err=0.
- All 4 requesters valid continuously (pending preset for x1..x4), awb_ready=1 → grants 0,1,2,3,0 on consecutive cycles; one writeback/cycle. Fixed-prio build: requester 0 every cycle.
- awb_ready=0 for 3 cycles with a pending entry plus 2 more requesters waiting → awb_addr/awb_data stable, req_ready=0; on ready, next grant issues in the same cycle.
- issue_valid for x7 in the same cycle as an awb handshake on x7 → pending[7]=1 afterwards; issue_addr=0 → pending unchanged.
- Requester 1 presents addr 9 with pending[9]=0 → forwarded, awb_err=1 and stays 1 until reset.
- Reset asserted while awb_valid=1 and awb_ready=0 → next cycle awb_valid=0, pending=0, awb_err=0; round-robin restarts at requester 0.
